dispatch_demux4: RTL and testbench
==================================

# dispatch_demux4

Pipeline-side 1-to-4 dispatch demultiplexer. It is the inverse of the 4-to-1 operand/result selectors. A single 32-bit producer stream tagged with a 2-bit destination is routed into one of four per-channel FIFOs. Each channel drains to its own consumer under an independent valid/ready handshake. It sits between the decode/issue stage and the execution-side consumers (ALU, branch, load/store, CSR queues), so that one stalled consumer never blocks words bound for another channel once those words are buffered.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per channel FIFO; a power of 2, at least 2.
- CLK  in  1  single clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  producer presents a word.
- IN_READY  out  1  selected channel can accept the word.
- IN_DATA  in  WIDTH  producer word.
- IN_SEL  in  2  destination channel (0..3); sampled with IN_DATA.
- OUT_VALID  out  4  bit i: channel i head word valid.
- OUT_READY  in  4  bit i: consumer i accepts the head word.
- OUT1_DATA..OUT4_DATA  out  WIDTH each  head word of channels 0..3.
- OUT_LEVEL  out  4×($clog2(DEPTH)+1)  packed per-channel occupancy; channel i in slice i.

## Operation
- Input transfer occurs when IN_VALID && IN_READY at a rising edge. Channel IN_SEL then pushes IN_DATA.
- IN_READY = !full[IN_SEL]. It depends only on registered occupancy and IN_SEL, never on OUT_READY. There is no combinational IN_READY←OUT_READY path.
- Output transfer on channel i occurs when OUT_VALID[i] && OUT_READY[i]. The head entry is popped.
- OUT_VALID[i] = (level[i] != 0), except for the bypass term described in Configuration.
- Channels are independent. All four may pop in the same cycle as one push.
- Push and pop on the same channel in the same cycle: the level is unchanged, and the new word is written at the tail while the head advances. When full, the push is refused by IN_READY=0, even if that channel pops that cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is 0..DEPTH. Ordering is FIFO per channel. There is no ordering guarantee across channels.
- OUTn_DATA is don't-care while OUT_VALID is low. Implementations drive the array head.
- IN_DATA and IN_SEL are only sampled on a transfer. Changing them while IN_READY=0 is legal.

## Timing
- Reset (RST_N low, asynchronous) sets:
  - all pointers and levels to 0;
  - OUT_VALID=4'b0 and OUT_LEVEL=0;
  - IN_READY=0 while RST_N is low;
  - IN_READY=1 from the first cycle after deassertion.
- Entry data is not reset.
- Reset mid-operation discards all buffered words. There is no partial pop.
- Latency with bypass compiled out: a word pushed at edge k gives OUT_VALID high in cycle k+1. It is poppable at edge k+1 at the earliest.
- Throughput: one push per cycle aggregate, one pop per cycle per channel.
- A full channel deasserts IN_READY for that IN_SEL only. The producer may switch IN_SEL to a non-full channel in the same cycle and get IN_READY=1 combinationally.

## Configuration
- DISPATCH_DEMUX_BYPASS_EN defined:
  - When channel IN_SEL is empty and IN_VALID is high, OUT_VALID[IN_SEL] is asserted combinationally and OUTn_DATA=IN_DATA.
  - If OUT_READY[IN_SEL] is also high, the word is consumed with zero latency and is not written to the FIFO; the level stays 0.
  - If OUT_READY[IN_SEL] is low, the word is pushed normally.
  - This adds an IN_VALID/IN_DATA→OUT combinational path. IN_READY remains independent of OUT_READY.
- Undefined: no bypass. Minimum latency is 1 cycle, and all outputs are registered-state driven.

## Test plan
- Reset: hold RST_N=0 mid-stream with channel 2 holding 2 words → OUT_VALID=0000, OUT_LEVEL=0, IN_READY=0. After release, IN_READY=1 and no stale word appears.
- Routing/order: push 0xA0,0xA1 to ch1 and 0xB0 to ch3 with OUT_READY=0000 → OUT_VALID=1010, OUT2_DATA=0xA0. Then OUT_READY=0010 yields 0xA0, then 0xA1; ch3 is untouched.
- Full/backpressure: push 2 words to ch0 with DEPTH=2 and OUT_READY[0]=0 → IN_READY=0 with IN_SEL=0. Switching IN_SEL=2 gives IN_READY=1 in the same cycle, and the push is accepted.
- Simultaneous push/pop at level 1 on ch2 → level stays 1 and the next head is the new word. At full with a pop that cycle, the push is refused and level goes 2→1.
- Wrap: stream 10 words 0x0..0x9 to ch1 with OUT_READY[1] toggling every cycle → the consumer receives 0x0..0x9 in order, with no loss or duplication.
- Bypass (DISPATCH_DEMUX_BYPASS_EN): empty ch3, IN_VALID=1, IN_SEL=3, IN_DATA=0x55, OUT_READY[3]=1 → OUT4_DATA=0x55 and OUT_VALID[3]=1 in the same cycle, and the level stays 0. With the macro undefined, OUT_VALID[3] rises 1 cycle later.

Source files
------------

// File: rtl/dispatch_demux4_if.sv
// Producer/consumer bundle for the 1-to-4 dispatch demultiplexer.
// master = producer and consumers side, slave = the demux itself.
interface dispatch_demux4_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic [WIDTH-1:0] out4_data;
    logic [4*LW-1:0]  out_level;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out1_data, out2_data, out3_data, out4_data, out_level
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out1_data, out2_data, out3_data, out4_data, out_level
    );
endinterface

// File: rtl/dispatch_demux4.sv
// 1-to-4 dispatch demux: one tagged producer stream into four independent FIFOs.
// Optional zero-latency bypass into an empty channel: define DISPATCH_DEMUX_BYPASS_EN.
module dispatch_demux4 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dispatch_demux4_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [3:0]       w_full;
    logic [3:0]       w_valid;
    logic [WIDTH-1:0] w_head  [4];
    logic [LW-1:0]    w_level [4];
    logic             w_accept;

    // Ready looks only at registered occupancy of the addressed channel.
    assign bus.in_ready = i_rst_n && !w_full[bus.in_sel];
    assign w_accept     = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_wptr;
            logic [PW-1:0]    r_rptr;
            logic [LW-1:0]    r_level;
            logic             w_sel;
            logic             w_empty;
            logic             w_push;
            logic             w_pop;
            logic             w_byp_valid;
            logic             w_bypass;

            assign w_sel      = (bus.in_sel == 2'(gi));
            assign w_empty    = (r_level == '0);
            assign w_full[gi] = (r_level == LW'(DEPTH));

`ifdef DISPATCH_DEMUX_BYPASS_EN
            // An empty channel presents the incoming word directly; if taken
            // right away it never touches the array.
            assign w_byp_valid = i_rst_n && bus.in_valid && w_sel && w_empty;
            assign w_bypass    = w_byp_valid && bus.out_ready[gi];
            assign w_head[gi]  = w_byp_valid ? bus.in_data : r_mem[r_rptr];
`else
            assign w_byp_valid = 1'b0;
            assign w_bypass    = 1'b0;
            assign w_head[gi]  = r_mem[r_rptr];
`endif

            assign w_push      = w_accept && w_sel && !w_bypass;
            assign w_pop       = !w_empty && bus.out_ready[gi];
            assign w_valid[gi] = !w_empty || w_byp_valid;
            assign w_level[gi] = r_level;

            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= bus.in_data;
                end
            end

            // Pointers wrap naturally because DEPTH is a power of two.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_level <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_level <= r_level + 1'b1;
                        2'b01:   r_level <= r_level - 1'b1;
                        default: r_level <= r_level;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        bus.out_level = '0;
        for (int i = 0; i < 4; i++) begin
            bus.out_level[i*LW +: LW] = w_level[i];
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out1_data = w_head[0];
    assign bus.out2_data = w_head[1];
    assign bus.out3_data = w_head[2];
    assign bus.out4_data = w_head[3];
endmodule

// File: tb/tb_dispatch_demux4.sv
// Directed bench for dispatch_demux4 (WIDTH=32, DEPTH=2); bypass checks follow
// DISPATCH_DEMUX_BYPASS_EN.
module tb_dispatch_demux4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int LW    = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   sent;
    int   recv;
    logic push;
    logic pop;

    dispatch_demux4_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dispatch_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] lvl(input int ch);
        return 32'(bus.out_level[ch*LW +: LW]);
    endfunction

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_level", 32'(bus.out_level), 32'h0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(bus.in_ready), 32'h1);

        // Routing and order: A0,A1 -> ch1, B0 -> ch3
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hA0; cyc();
        bus.in_data = 32'hA1; cyc();
        bus.in_sel = 2'd3; bus.in_data = 32'hB0; cyc();
        bus.in_valid = 1'b0;
        #1;
        check_eq("route_valid", 32'(bus.out_valid), 32'b1010);
        check_eq("route_head1", bus.out2_data, 32'hA0);
        check_eq("route_level", 32'(bus.out_level), 32'h48);
        bus.out_ready = 4'b0010;
        #1;
        check_eq("pop1_a0", bus.out2_data, 32'hA0);
        cyc();
        check_eq("pop1_a1", bus.out2_data, 32'hA1);
        check_eq("pop1_lvl", lvl(1), 32'd1);
        cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("ch3_untouched_v", 32'(bus.out_valid), 32'b1000);
        check_eq("ch3_untouched_d", bus.out4_data, 32'hB0);
        bus.out_ready = 4'b1000;
        cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("drained", 32'(bus.out_valid), 32'h0);

        // Full / backpressure on ch0, switch to ch2
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'hC0; cyc();
        bus.in_data = 32'hC1; cyc();
        bus.in_data = 32'hC2;
        #1;
        check_eq("full_ready0", 32'(bus.in_ready), 32'h0);
        check_eq("full_lvl0", lvl(0), 32'd2);
        bus.in_sel = 2'd2; bus.in_data = 32'hD0;
        #1;
        check_eq("switch_ready2", 32'(bus.in_ready), 32'h1);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check_eq("switch_lvl2", lvl(2), 32'd1);
        check_eq("switch_head2", bus.out3_data, 32'hD0);
        check_eq("full_lvl0_kept", lvl(0), 32'd2);

        // Simultaneous push/pop at level 1 on ch2
        bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'hD1; bus.out_ready = 4'b0100;
        #1;
        check_eq("pp_head_before", bus.out3_data, 32'hD0);
        cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("pp_lvl", lvl(2), 32'd1);
        check_eq("pp_head_after", bus.out3_data, 32'hD1);
        bus.in_data = 32'hD2; cyc();
        // Full with pop in the same cycle: push refused
        bus.in_data = 32'hD3; bus.out_ready = 4'b0100;
        #1;
        check_eq("fullpop_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        #1;
        check_eq("fullpop_lvl", lvl(2), 32'd1);
        check_eq("fullpop_head", bus.out3_data, 32'hD2);
        bus.out_ready = 4'b0100; cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("ch2_empty", 32'(bus.out_valid[2]), 32'h0);
        check_eq("ch0_head_c0", bus.out1_data, 32'hC0);
        bus.out_ready = 4'b0001; cyc();
        check_eq("ch0_head_c1", bus.out1_data, 32'hC1);
        cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("all_empty", 32'(bus.out_valid), 32'h0);

        // Reset mid-stream with ch2 holding two words
        bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'hE0; cyc();
        bus.in_data = 32'hE1; cyc();
        bus.in_sel = 2'd1; bus.in_data = 32'hE2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("midrst_level", 32'(bus.out_level), 32'h0);
        check_eq("midrst_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_eq("midrst_rel_ready", 32'(bus.in_ready), 32'h1);
        cyc();
        check_eq("midrst_no_stale", 32'(bus.out_valid), 32'h0);

        // Wrap: 10 words to ch1, consumer ready toggles every cycle
        sent = 0;
        recv = 0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            bus.in_valid  = (sent < 10);
            bus.in_sel    = 2'd1;
            bus.in_data   = 32'(sent);
            bus.out_ready = {2'b00, c[0], 1'b0};
            #1;
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid[1] && bus.out_ready[1];
            if (pop) begin
                check_eq("wrap_data", bus.out2_data, 32'(recv));
                recv++;
            end
            cyc();
            if (push) sent++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        #1;
        check_eq("wrap_recv", 32'(recv), 32'd10);
        check_eq("wrap_sent", 32'(sent), 32'd10);
        check_eq("wrap_empty", 32'(bus.out_valid), 32'h0);

        // Bypass into empty ch3
        bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 32'h55; bus.out_ready = 4'b1000;
        #1;
`ifdef DISPATCH_DEMUX_BYPASS_EN
        check_eq("byp_valid", 32'(bus.out_valid[3]), 32'h1);
        check_eq("byp_data", bus.out4_data, 32'h55);
        cyc();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        #1;
        check_eq("byp_lvl", lvl(3), 32'd0);
        check_eq("byp_after_valid", 32'(bus.out_valid[3]), 32'h0);
`else
        check_eq("nobyp_valid0", 32'(bus.out_valid[3]), 32'h0);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check_eq("nobyp_valid1", 32'(bus.out_valid[3]), 32'h1);
        check_eq("nobyp_data", bus.out4_data, 32'h55);
        cyc();
        bus.out_ready = 4'b0000;
        #1;
        check_eq("nobyp_lvl", lvl(3), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
